cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single CDB among the RS-owned functional units. Each FU delivers a
//  result (ROB tag + value) into a 1-deep per-requester hold buffer. A round-robin
//  arbiter broadcasts one buffered result per cycle as a registered CDB_PACKET.
//  The same cycle, it pulses the matching fu_done bit so the RS frees that entry.
//  Sits between FU outputs and the RS/ROB/map-table CDB inputs.
// PARAMETERS
//  NUM_REQ    6   requesters; requester i <-> RS entry i+1 (equals `NUM_RS)
//  XLEN       32  result value width
//  ROB_TAG_W  5   ROB tag width; tag 0 (`ZERO_REG) = no tag
// PORTS
//  clock         in   1                  system clock
//  reset         in   1                  asynchronous, active-high
//  squash        in   1                  synchronous flush (mispredict)
//  fu_req_valid  in   NUM_REQ            FU i presents a result
//  fu_req_tag    in   NUM_REQ*ROB_TAG_W  ROB tag per requester
//  fu_req_value  in   NUM_REQ*XLEN       result value per requester
//  fu_req_ready  out  NUM_REQ            hold buffer i can accept this cycle
//  cdb_valid     out  1                  CDB carries a result
//  cdb_rob_tag   out  ROB_TAG_W          broadcast tag
//  cdb_value     out  XLEN               broadcast value
//  fu_done       out  NUM_REQ+1          one-hot free pulse, bit i+1 = RS entry i+1; bit 0 always 0
//  starve_err    out  1                  sticky: a held result waited > NUM_REQ cycles
// BEHAVIOUR
//  - Reset (async): all hold_valid=0, rr_ptr=0, cdb_valid=0, cdb_rob_tag=0,
//    cdb_value=0, fu_done=0, starve_err=0, all wait counters=0.
//  - fu_req_ready[i] = ~hold_valid[i] | grant[i] (drain and refill in the same
//    cycle). Combinational, no dependence on fu_req_valid. Forced 0 while squash=1.
//  - Accept: fu_req_valid[i] & fu_req_ready[i] at edge -> hold_valid[i]=1, tag/value latched.
//    A request with tag==0 is consumed (ready honoured) but not buffered.
//    The protocol is violated if valid drops before ready; the behaviour is then unspecified.
//  - Arbitration (comb): grant = first hold_valid[j] scanning j = rr_ptr,
//    rr_ptr+1, ... mod NUM_REQ. At most one grant per cycle.
//  - On grant g at edge: cdb_valid<=1, cdb_rob_tag<=tag[g], cdb_value<=val[g],
//    fu_done<=1<<(g+1), hold_valid[g]<=0 (unless refilled the same edge),
//    rr_ptr<=(g+1) mod NUM_REQ. With no grant: cdb_valid<=0, fu_done<=0, tag/value <= 0.
//  - Latency: request accepted at edge E -> earliest CDB/fu_done visible after E+1
//    (1 cycle in buffer + registered output). Exactly 1 cycle at minimum.
//  - Throughput: 1 result/cycle sustained. A requester refilling every cycle cannot
//    block the others (RR): worst-case wait is NUM_REQ-1 grants.
//  - cdb_valid / fu_done are 1-cycle pulses per result; never two bits set in fu_done.
//  - Squash (sync, priority over everything except reset): hold_valid<=0,
//    cdb_valid<=0, fu_done<=0, tag/value <= 0. Requests and grant in that cycle are dropped.
//    rr_ptr is kept. starve_err and the wait counters clear.
//  - Wait counter per buffer: increments while hold_valid & ~grant, clears on grant.
//    Saturates at NUM_REQ+1. Reaching NUM_REQ+1 sets starve_err (sticky until
//    reset/squash); this is an assertion hook and never fires in a correct design.
//  - Reset mid-operation: all buffered results are lost, with no partial broadcast.
// STRUCTURE
//  - CDB_PACKET (rob_tag, v), ROB_TAG and RS_TAG typedefs are shared in sys_defs.svh.
//    cdb_valid/rob_tag/value pack into CDB_PACKET at the top level.
//  - Sub-module rr_arbiter #(N): req[N], ptr -> one-hot grant[N] + grant index.
//    Purely combinational, reused by a future issue selector.
//  - This module holds the hold buffers, pointer, output regs and wait counters.
// TESTING
//  1 Reset: assert reset mid-cycle with buffers full -> all outputs 0 immediately
//    and after release; ready=all 1.
//  2 Single: req2 tag=5 val=0xDEAD at edge E -> after E+1, cdb_valid=1, tag=5,
//    value=0xDEAD, fu_done=7'b0001000; one cycle only.
//  3 Contention: reqs 0,1,3 valid together, rr_ptr=0 -> CDB order tags of 0,1,3 on
//    3 consecutive cycles; rr_ptr ends 4.
//  4 Fairness: req0 valid every cycle with tag 1, req5 tag 9 once -> tag 9 broadcast
//    within 2 cycles of acceptance; starve_err stays 0.
//  5 Squash: fill buffers 0-5, then squash for 1 cycle -> next cycle cdb_valid=0,
//    fu_done=0, ready=all 1; no stale tag ever broadcast.
//  6 Tag 0: req4 tag=0 -> ready=1, no CDB pulse, fu_done bit 5 never set.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// Module : cdb_arbiter_pkg
// Brief  : Shared CDB types, sizes and helpers for the CDB arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;
   localparam int NUM_RS        = 6;
   localparam int XLEN_DEF      = 32;
   localparam int ROB_TAG_W_DEF = 5;
   localparam int ZERO_REG      = 0;

   typedef logic [ROB_TAG_W_DEF-1:0]     ROB_TAG;
   typedef logic [$clog2(NUM_RS+1)-1:0]  RS_TAG;

   typedef struct packed {
      ROB_TAG               rob_tag;
      logic [XLEN_DEF-1:0]  v;
   } CDB_PACKET;

   // Index width that stays legal for a single requester.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N = 6
) (
   input  logic [N-1:0]              req,
   input  logic [ptr_width(N)-1:0]   ptr,
   output logic [N-1:0]              grant,
   output logic [ptr_width(N)-1:0]   grant_idx,
   output logic                      grant_valid
);
   localparam int PTR_W = ptr_width(N);

   logic             w_found_hi;
   logic [PTR_W-1:0] w_hi_idx;
   logic [PTR_W-1:0] w_lo_idx;

   // Lowest request at/above ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_found_hi  = 1'b0;
      w_hi_idx    = '0;
      w_lo_idx    = '0;
      grant_valid = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (req[i]) begin
            grant_valid = 1'b1;
            w_lo_idx    = PTR_W'(i);
            if (PTR_W'(i) >= ptr) begin
               w_found_hi = 1'b1;
               w_hi_idx   = PTR_W'(i);
            end
         end
      end
      grant_idx = w_found_hi ? w_hi_idx : w_lo_idx;
      grant     = grant_valid ? (N'(1) << grant_idx) : '0;
   end
endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : Hold buffers per FU, round-robin CDB broadcast, fu_done free pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_RS,
   parameter int XLEN      = XLEN_DEF,
   parameter int ROB_TAG_W = ROB_TAG_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      squash,
   input  logic [NUM_REQ-1:0]        fu_req_valid,
   input  logic [NUM_REQ*ROB_TAG_W-1:0] fu_req_tag,
   input  logic [NUM_REQ*XLEN-1:0]   fu_req_value,
   output logic [NUM_REQ-1:0]        fu_req_ready,
   output logic                      cdb_valid,
   output logic [ROB_TAG_W-1:0]      cdb_rob_tag,
   output logic [XLEN-1:0]           cdb_value,
   output logic [NUM_REQ:0]          fu_done,
   output logic                      starve_err
);
   localparam int               PTR_W   = ptr_width(NUM_REQ);
   localparam int               CNT_W   = $clog2(NUM_REQ+2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_REQ+1);

   // Same layout as CDB_PACKET, sized by this instance's parameters.
   typedef struct packed {
      logic [ROB_TAG_W-1:0] rob_tag;
      logic [XLEN-1:0]      v;
   } cdb_packet_t;

   logic [NUM_REQ-1:0]   r_hold_valid;
   logic [ROB_TAG_W-1:0] r_hold_tag   [NUM_REQ];
   logic [XLEN-1:0]      r_hold_value [NUM_REQ];
   logic [CNT_W-1:0]     r_wait_cnt   [NUM_REQ];
   logic [PTR_W-1:0]     r_rr_ptr;
   cdb_packet_t          r_cdb;
   logic                 r_cdb_valid;
   logic [NUM_REQ:0]     r_fu_done;
   logic                 r_starve_err;

   logic [ROB_TAG_W-1:0] w_req_tag   [NUM_REQ];
   logic [XLEN-1:0]      w_req_value [NUM_REQ];
   logic [NUM_REQ-1:0]   w_grant;
   logic [NUM_REQ-1:0]   w_accept;
   logic [NUM_REQ-1:0]   w_starved;
   logic [PTR_W-1:0]     w_grant_idx;
   logic                 w_grant_valid;

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
         assign w_req_tag[i]   = fu_req_tag[i*ROB_TAG_W +: ROB_TAG_W];
         assign w_req_value[i] = fu_req_value[i*XLEN +: XLEN];
         assign w_starved[i]   = (r_wait_cnt[i] == CNT_MAX);
      end
   endgenerate

   // A buffer being drained this cycle can take a new result at the same edge.
   assign fu_req_ready = squash ? '0 : (~r_hold_valid | w_grant);
   assign w_accept     = fu_req_valid & fu_req_ready;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req         (r_hold_valid),
      .ptr         (r_rr_ptr),
      .grant       (w_grant),
      .grant_idx   (w_grant_idx),
      .grant_valid (w_grant_valid)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hold_valid <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_hold_tag[i]   <= '0;
            r_hold_value[i] <= '0;
            r_wait_cnt[i]   <= '0;
         end
      end else if (squash) begin
         r_hold_valid <= '0;
         for (int i = 0; i < NUM_REQ; i++) r_wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            // Tag zero means "no destination": handshake completes, nothing stored.
            if (w_accept[i] && (w_req_tag[i] != ROB_TAG_W'(ZERO_REG))) begin
               r_hold_valid[i] <= 1'b1;
               r_hold_tag[i]   <= w_req_tag[i];
               r_hold_value[i] <= w_req_value[i];
            end else if (w_grant[i]) begin
               r_hold_valid[i] <= 1'b0;
            end
            if (w_grant[i])
               r_wait_cnt[i] <= '0;
            else if (r_hold_valid[i] && !w_starved[i])
               r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rr_ptr     <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb        <= '0;
         r_fu_done    <= '0;
         r_starve_err <= 1'b0;
      end else if (squash) begin
         r_cdb_valid  <= 1'b0;
         r_cdb        <= '0;
         r_fu_done    <= '0;
         r_starve_err <= 1'b0;
      end else begin
         if (|w_starved) r_starve_err <= 1'b1;
         if (w_grant_valid) begin
            r_cdb_valid   <= 1'b1;
            r_cdb.rob_tag <= r_hold_tag[w_grant_idx];
            r_cdb.v       <= r_hold_value[w_grant_idx];
            r_fu_done     <= {w_grant, 1'b0};
            r_rr_ptr      <= (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
         end else begin
            r_cdb_valid <= 1'b0;
            r_cdb       <= '0;
            r_fu_done   <= '0;
         end
      end
   end

   assign cdb_valid   = r_cdb_valid;
   assign cdb_rob_tag = r_cdb.rob_tag;
   assign cdb_value   = r_cdb.v;
   assign fu_done     = r_fu_done;
   assign starve_err  = r_starve_err;
endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Self-checking bench for cdb_arbiter (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
   localparam int NR = 6;
   localparam int XL = 32;
   localparam int TW = 5;

   logic              clock;
   logic              reset;
   logic              squash;
   logic [NR-1:0]     fu_req_valid;
   logic [NR*TW-1:0]  fu_req_tag;
   logic [NR*XL-1:0]  fu_req_value;
   logic [NR-1:0]     fu_req_ready;
   logic              cdb_valid;
   logic [TW-1:0]     cdb_rob_tag;
   logic [XL-1:0]     cdb_value;
   logic [NR:0]       fu_done;
   logic              starve_err;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [XL-1:0] value;
      logic [NR:0]   done;
   } exp_t;

   typedef struct packed {
      logic [2:0]    idx;
      logic [TW-1:0] tag;
      logic [XL-1:0] value;
      logic          exp_valid;
      logic [NR:0]   exp_done;
   } vec_t;

   exp_t          sb_q[$];
   vec_t          vecs[7];
   logic [NR-1:0] ready_snap;
   int            checks   = 0;
   int            failures = 0;

   cdb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .ROB_TAG_W(TW)) dut (
      .clock        (clock),
      .reset        (reset),
      .squash       (squash),
      .fu_req_valid (fu_req_valid),
      .fu_req_tag   (fu_req_tag),
      .fu_req_value (fu_req_value),
      .fu_req_ready (fu_req_ready),
      .cdb_valid    (cdb_valid),
      .cdb_rob_tag  (cdb_rob_tag),
      .cdb_value    (cdb_value),
      .fu_done      (fu_done),
      .starve_err   (starve_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every cycle: any broadcast must match the head of the scoreboard.
   task automatic monitor();
      exp_t e;
      if (cdb_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("cdb_unexpected", 64'(cdb_valid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("cdb_tag",   64'(cdb_rob_tag), 64'(e.tag));
            check("cdb_value", 64'(cdb_value),   64'(e.value));
            check("cdb_done",  64'(fu_done),     64'(e.done));
         end
      end else begin
         check("idle_done", 64'(fu_done), 64'd0);
      end
      check("starve_err", 64'(starve_err), 64'd0);
   endtask

   task automatic tick();
      @(negedge clock);
      ready_snap = fu_req_ready;
      @(posedge clock);
      #1;
      monitor();
   endtask

   task automatic set_req(input int i, input logic [TW-1:0] t, input logic [XL-1:0] v);
      fu_req_valid[i]          = 1'b1;
      fu_req_tag[i*TW +: TW]   = t;
      fu_req_value[i*XL +: XL] = v;
   endtask

   task automatic clr_req(input int i);
      fu_req_valid[i] = 1'b0;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      squash       = 1'b0;
      fu_req_valid = '0;
      @(posedge clock);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      vec_t v;
      fu_req_tag   = '0;
      fu_req_value = '0;
      vecs[0] = '{idx:3'd2, tag:5'd5,  value:32'hDEAD,      exp_valid:1'b1, exp_done:7'b0001000};
      vecs[1] = '{idx:3'd0, tag:5'd1,  value:32'h1234_5678, exp_valid:1'b1, exp_done:7'b0000010};
      vecs[2] = '{idx:3'd5, tag:5'd31, value:32'hFFFF_FFFF, exp_valid:1'b1, exp_done:7'b1000000};
      vecs[3] = '{idx:3'd4, tag:5'd0,  value:32'hBEEF,      exp_valid:1'b0, exp_done:7'b0000000};
      vecs[4] = '{idx:3'd3, tag:5'd17, value:32'h0,         exp_valid:1'b1, exp_done:7'b0010000};
      vecs[5] = '{idx:3'd1, tag:5'd2,  value:32'hA5A5_A5A5, exp_valid:1'b1, exp_done:7'b0000100};
      vecs[6] = '{idx:3'd4, tag:5'd12, value:32'hCAFE,      exp_valid:1'b1, exp_done:7'b0100000};

      // Reset state
      do_reset();
      check("rst_valid", 64'(cdb_valid),    64'd0);
      check("rst_tag",   64'(cdb_rob_tag),  64'd0);
      check("rst_value", 64'(cdb_value),    64'd0);
      check("rst_done",  64'(fu_done),      64'd0);
      check("rst_ready", 64'(fu_req_ready), 64'h3F);

      // Reset mid-operation with all buffers full
      for (int i = 0; i < NR; i++) set_req(i, TW'(i+1), 32'h1000 + 32'(i));
      sb_q.push_back('{tag:5'd1, value:32'h1000, done:7'b0000010});
      tick();
      fu_req_valid = '0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("midrst_valid", 64'(cdb_valid),    64'd0);
      check("midrst_tag",   64'(cdb_rob_tag),  64'd0);
      check("midrst_value", 64'(cdb_value),    64'd0);
      check("midrst_done",  64'(fu_done),      64'd0);
      check("midrst_ready", 64'(fu_req_ready), 64'h3F);
      @(posedge clock);
      #2;
      reset = 1'b0;
      tick();
      tick();
      check("midrst_after_valid", 64'(cdb_valid), 64'd0);
      check("midrst_sb_empty", 64'(sb_q.size()), 64'd0);

      // Single-request vector table (includes tag-0 consumption)
      for (int k = 0; k < 7; k++) begin
         v = vecs[k];
         set_req(int'(v.idx), v.tag, v.value);
         if (v.exp_valid) sb_q.push_back('{tag:v.tag, value:v.value, done:v.exp_done});
         tick();
         check($sformatf("vec%0d_ready", k), 64'(ready_snap[v.idx]), 64'd1);
         clr_req(int'(v.idx));
         tick();
         check($sformatf("vec%0d_pulse", k), 64'(cdb_valid), 64'(v.exp_valid));
         check($sformatf("vec%0d_done", k),  64'(fu_done),   64'(v.exp_done));
         tick();
         check($sformatf("vec%0d_pulse_end", k), 64'(cdb_valid), 64'd0);
      end

      // Contention from rr_ptr=0, then prove pointer landed on 4
      do_reset();
      set_req(0, 5'd3,  32'h30);
      set_req(1, 5'd7,  32'h70);
      set_req(3, 5'd11, 32'hB0);
      sb_q.push_back('{tag:5'd3,  value:32'h30, done:7'b0000010});
      sb_q.push_back('{tag:5'd7,  value:32'h70, done:7'b0000100});
      sb_q.push_back('{tag:5'd11, value:32'hB0, done:7'b0010000});
      tick();
      fu_req_valid = '0;
      tick(); check("cont_t1", 64'(cdb_rob_tag), 64'd3);
      tick(); check("cont_t2", 64'(cdb_rob_tag), 64'd7);
      tick(); check("cont_t3", 64'(cdb_rob_tag), 64'd11);
      tick(); check("cont_end", 64'(cdb_valid), 64'd0);
      set_req(3, 5'd13, 32'hD3);
      set_req(5, 5'd15, 32'hF5);
      sb_q.push_back('{tag:5'd15, value:32'hF5, done:7'b1000000});
      sb_q.push_back('{tag:5'd13, value:32'hD3, done:7'b0010000});
      tick();
      fu_req_valid = '0;
      tick(); check("ptr4_first",  64'(cdb_rob_tag), 64'd15);
      tick(); check("ptr4_second", 64'(cdb_rob_tag), 64'd13);
      tick();

      // Fairness: req0 streaming cannot starve req5
      do_reset();
      set_req(0, 5'd1, 32'h11);
      set_req(5, 5'd9, 32'h99);
      sb_q.push_back('{tag:5'd1, value:32'h11, done:7'b0000010});
      sb_q.push_back('{tag:5'd9, value:32'h99, done:7'b1000000});
      sb_q.push_back('{tag:5'd1, value:32'h11, done:7'b0000010});
      sb_q.push_back('{tag:5'd1, value:32'h11, done:7'b0000010});
      tick();
      check("fair_rdy0_e1", 64'(ready_snap[0]), 64'd1);
      check("fair_rdy5_e1", 64'(ready_snap[5]), 64'd1);
      clr_req(5);
      tick();
      check("fair_rdy0_e2", 64'(ready_snap[0]), 64'd1);
      tick();
      check("fair_rdy0_e3", 64'(ready_snap[0]), 64'd0);
      check("fair_tag9",    64'(cdb_rob_tag),   64'd9);
      tick();
      check("fair_rdy0_e4", 64'(ready_snap[0]), 64'd1);
      clr_req(0);
      tick();
      tick();
      check("fair_idle", 64'(cdb_valid), 64'd0);
      check("fair_sb_empty", 64'(sb_q.size()), 64'd0);

      // Squash with all buffers full; a request during squash is dropped
      for (int i = 0; i < NR; i++) set_req(i, TW'(20+i), 32'h2000 + 32'(i));
      tick();
      check("sq_fill_ready", 64'(ready_snap), 64'h3F);
      fu_req_valid = '0;
      set_req(2, 5'd30, 32'h3333);
      squash = 1'b1;
      #1;
      check("sq_ready_low", 64'(fu_req_ready), 64'd0);
      tick();
      squash = 1'b0;
      clr_req(2);
      #1;
      check("sq_valid", 64'(cdb_valid),    64'd0);
      check("sq_done",  64'(fu_done),      64'd0);
      check("sq_tag",   64'(cdb_rob_tag),  64'd0);
      check("sq_ready", 64'(fu_req_ready), 64'h3F);
      repeat (4) tick();
      check("sq_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
